// File: rtl/psg_audio_pkg.sv
// Shared constants and sample type for the PSG audio output path.
package psg_audio_pkg;
  localparam int PSG_IN_W       = 22;
  localparam int DAC_W          = 16;
  localparam int I2S_FRAME_BITS = 32;

  typedef logic signed [DAC_W-1:0] dac_word_t;
endpackage

// File: rtl/psg_sample_sat.sv
// Combinational scaler: shifts the unsigned PSG sum down, clamps it to 16 bits
// and re-centres offset-binary into two's complement for the DAC.
module psg_sample_sat
  import psg_audio_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic [PSG_IN_W-1:0] si,
  output dac_word_t           w
);

  function automatic dac_word_t sat_flip(input logic [PSG_IN_W-1:0] x);
    logic [PSG_IN_W-1:0] s;
    logic [DAC_W-1:0]    u;
    s = x >> SHIFT;
    u = (s > PSG_IN_W'({DAC_W{1'b1}})) ? {DAC_W{1'b1}} : s[DAC_W-1:0];
    // Flipping the MSB turns the unsigned mid-scale into signed zero.
    return dac_word_t'(u ^ {1'b1, {(DAC_W-1){1'b0}}});
  endfunction

  assign w = sat_flip(si);

endmodule

// File: rtl/psg_i2s_transmitter.sv
// Mono I2S transmitter: captures a PSG sample on cnt==0 into a single holding
// buffer and sends it in both slots of the next frame, flagging over/underrun.
module psg_i2s_transmitter
  import psg_audio_pkg::*;
#(
  parameter int SHIFT    = 4,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          cnt,
  input  logic [PSG_IN_W-1:0] si,
  output logic                bclk_o,
  output logic                lrck_o,
  output logic                sdata_o,
  output logic                underrun_o,
  output logic                overrun_o
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(I2S_FRAME_BITS);
  localparam int IDX_W = $clog2(DAC_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LR_FIRST  = BIT_W'(DAC_W - 1);
  localparam logic [BIT_W-1:0] LR_LAST   = BIT_W'(I2S_FRAME_BITS - 2);
  localparam logic [IDX_W-1:0] MSB_IDX   = IDX_W'(DAC_W - 1);

  dac_word_t        word_p0;
  dac_word_t        hold_q;
  dac_word_t        last_q;
  dac_word_t        sh_q;
  dac_word_t        sh_nx;
  logic             valid_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic [BIT_W-1:0] bit_nx;
  logic [IDX_W-1:0] bit_idx;
  logic             div_tc;
  logic             fall;
  logic             load;
  logic             cap;
  logic             lrck_nx;

  psg_sample_sat #(
    .SHIFT(SHIFT)
  ) u_sat (
    .si(si),
    .w (word_p0)
  );

  always_comb begin
    div_tc  = (div_q == DIV_LAST);
    fall    = div_tc & bclk_o;
    bit_nx  = bit_q + 1'b1;
    load    = fall && (bit_nx == '0);
    cap     = (cnt == 8'd0);
    sh_nx   = sh_q;
    if (load) begin
      sh_nx = valid_q ? hold_q : last_q;
    end
    // Both slots carry the same word, so the low nibble of b indexes it.
    bit_idx = MSB_IDX - bit_nx[IDX_W-1:0];
    lrck_nx = (bit_nx >= LR_FIRST) && (bit_nx <= LR_LAST);
  end

  // Stage boundary: registered I2S outputs, buffers and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= '0;
      bit_q      <= '1;
      bclk_o     <= 1'b0;
      lrck_o     <= 1'b0;
      sdata_o    <= 1'b0;
      underrun_o <= 1'b0;
      overrun_o  <= 1'b0;
      hold_q     <= '0;
      last_q     <= '0;
      sh_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      overrun_o  <= 1'b0;
      div_q      <= div_tc ? '0 : div_q + 1'b1;
      if (div_tc) begin
        bclk_o <= ~bclk_o;
      end
      if (fall) begin
        bit_q   <= bit_nx;
        sh_q    <= sh_nx;
        sdata_o <= sh_nx[bit_idx];
        lrck_o  <= lrck_nx;
      end
      if (load) begin
        if (valid_q) begin
          last_q  <= hold_q;
          valid_q <= 1'b0;
        end else begin
          underrun_o <= 1'b1;
        end
      end
      // A capture in the load cycle wins the valid flag and is not an overrun.
      if (cap) begin
        hold_q    <= word_p0;
        valid_q   <= 1'b1;
        overrun_o <= valid_q & ~load;
      end
    end
  end

endmodule

// File: tb/tb_psg_i2s_transmitter.sv
// Bench for psg_i2s_transmitter: time-based reference model plus directed scenarios.
module tb_psg_i2s_transmitter;
  localparam int BD = 4;
  localparam int SH = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  cnt = 8'd1;
  logic [21:0] si = '0;
  logic        bclk_o, lrck_o, sdata_o, underrun_o, overrun_o;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  logic [7:0]  cnt_s = 8'd1;
  logic [21:0] si_s = '0;

  always #5 clk = ~clk;

  psg_i2s_transmitter #(.SHIFT(SH), .BCLK_DIV(BD)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .cnt       (cnt),
    .si        (si),
    .bclk_o    (bclk_o),
    .lrck_o    (lrck_o),
    .sdata_o   (sdata_o),
    .underrun_o(underrun_o),
    .overrun_o (overrun_o)
  );

  // Edge number since reset release, plus the inputs seen at that edge.
  always @(posedge clk) begin
    edge_cnt <= rst_ni ? edge_cnt + 1 : 0;
    cnt_s    <= cnt;
    si_s     <= si;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  function automatic int conv(input int x);
    int s;
    s = x >> SH;
    if (s > 65535) s = 65535;
    return s ^ 32'h8000;
  endfunction

  // Reference model: everything derived from the edge number since release.
  int m_hold, m_last, m_frame;
  bit m_valid;
  int e_bclk, e_lrck, e_sd, e_ur, e_or;

  task automatic model_reset();
    m_hold = 0; m_last = 0; m_frame = 0; m_valid = 0;
    e_bclk = 0; e_lrck = 0; e_sd = 0; e_ur = 0; e_or = 0;
  endtask

  task automatic model_step(input int t);
    bit fall, load, pre_v;
    int b;
    pre_v = m_valid;
    e_ur = 0;
    e_or = 0;
    fall = (t % (2 * BD)) == 0;
    load = fall && ((((t / (2 * BD)) - 1) % 32) == 0);
    if (load) begin
      if (m_valid) begin
        m_frame = m_hold; m_last = m_hold; m_valid = 0;
      end else begin
        m_frame = m_last; e_ur = 1;
      end
    end
    if (cnt_s == 8'd0) begin
      e_or = (pre_v && !load) ? 1 : 0;
      m_hold = conv(int'(si_s));
      m_valid = 1;
    end
    e_bclk = (t / BD) % 2;
    if (t < 2 * BD) begin
      e_lrck = 0; e_sd = 0;
    end else begin
      b = ((t / (2 * BD)) - 1) % 32;
      e_lrck = (b >= 15 && b <= 30) ? 1 : 0;
      e_sd = (m_frame >> (15 - (b % 16))) & 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_ni || edge_cnt == 0) model_reset();
      else model_step(edge_cnt);
      check("bclk", 32'(bclk_o), 32'(e_bclk));
      check("lrck", 32'(lrck_o), 32'(e_lrck));
      check("sdata", 32'(sdata_o), 32'(e_sd));
      check("underrun", 32'(underrun_o), 32'(e_ur));
      check("overrun", 32'(overrun_o), 32'(e_or));
    end
  end

  // I2S receiver sampling on bclk rises, as the DAC would.
  logic [31:0] sr = '0;
  logic        prev_lr = 1'b0;
  logic [15:0] rx_left = '0;
  logic [15:0] rx_right = '0;
  always @(posedge bclk_o) begin
    sr      <= {sr[30:0], sdata_o};
    prev_lr <= lrck_o;
    if (!prev_lr && lrck_o) rx_left <= {sr[14:0], sdata_o};
    if (prev_lr && !lrck_o) rx_right <= {sr[14:0], sdata_o};
  end

  task automatic wait_edge(input int e);
    int guard = 0;
    while (edge_cnt < e && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_cnt < e) check("edge_timeout", 32'(edge_cnt), 32'(e));
  endtask

  task automatic capture(input int e, input logic [21:0] val);
    wait_edge(e - 1);
    cnt = 8'd0;
    si = val;
    wait_edge(e);
    cnt = 8'd1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bclk"}, 32'(bclk_o), 32'd0);
    check({tag, "_lrck"}, 32'(lrck_o), 32'd0);
    check({tag, "_sdata"}, 32'(sdata_o), 32'd0);
    check({tag, "_ur"}, 32'(underrun_o), 32'd0);
    check({tag, "_or"}, 32'(overrun_o), 32'd0);
  endtask

  initial begin
    int lr_hi, sd_hi, flags;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    rst_ni = 1'b1;

    // Idle: underruns on every frame, silent data, 16 bclks of right slot.
    wait_edge(8);
    check("ur_first", 32'(underrun_o), 32'd1);
    wait_edge(9);
    check("ur_pulse_end", 32'(underrun_o), 32'd0);
    lr_hi = 0; sd_hi = 0;
    for (int e = 9; e <= 264; e++) begin
      wait_edge(e);
      lr_hi += int'(lrck_o);
      sd_hi += int'(sdata_o);
    end
    check("lrck_hi_cycles", 32'(lr_hi), 32'd128);
    check("sdata_hi_cycles", 32'(sd_hi), 32'd0);
    check("ur_second", 32'(underrun_o), 32'd1);

    // Normal sample and I2S one-bit delay.
    capture(300, 22'h12345);
    wait_edge(511);
    check("lrck_pre_fall", 32'(lrck_o), 32'd1);
    wait_edge(512);
    check("lrck_fall", 32'(lrck_o), 32'd0);
    wait_edge(520);
    check("left_msb", 32'(sdata_o), 32'd1);
    wait_edge(780);
    check("word_left", 32'(rx_left), 32'h9234);
    check("word_right", 32'(rx_right), 32'h9234);

    // Saturation and full-scale negative.
    capture(800, 22'h3FFFFF);
    wait_edge(1290);
    check("sat_left", 32'(rx_left), 32'h7FFF);
    check("sat_right", 32'(rx_right), 32'h7FFF);
    capture(1300, 22'h0);
    wait_edge(1800);
    check("zero_left", 32'(rx_left), 32'h8000);
    check("zero_right", 32'(rx_right), 32'h8000);

    // Steady cnt wrap with cnt==0 landing on every frame load.
    flags = 0;
    for (int e = 2056; e <= 4104; e++) begin
      wait_edge(e - 1);
      if (e - 1 >= 2057) flags += int'(underrun_o) + int'(overrun_o);
      cnt = 8'((e - 8) % 256);
      si = 22'(e * 7993);
    end
    wait_edge(4104);
    flags += int'(underrun_o) + int'(overrun_o);
    cnt = 8'd1;
    check("steady_flags", 32'(flags), 32'd0);

    // Two captures in one frame: a single overrun, latest word wins.
    capture(4400, 22'h00010);
    check("ovr_first", 32'(overrun_o), 32'd0);
    capture(4410, 22'h00020);
    check("ovr_second", 32'(overrun_o), 32'd1);
    wait_edge(4870);
    check("ovr_left", 32'(rx_left), 32'h8002);
    check("ovr_right", 32'(rx_right), 32'h8002);

    // Asynchronous reset in the right slot.
    wait_edge(5050);
    check("mid_lrck", 32'(lrck_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    wait_edge(8);
    check("rst_ur", 32'(underrun_o), 32'd1);
    wait_edge(270);
    check("rst_left", 32'(rx_left), 32'h0000);
    check("rst_right", 32'(rx_right), 32'h0000);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
